// File: rtl/ogege_pkg.sv
// Shared video/PSRAM constants and the scanline fetch FSM state type.
package ogege_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COLOR_W  = 12;
  localparam int PSRAM_AW = 24;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT
  } fetch_state_t;
endpackage

// File: rtl/psram_line_fetch_if.sv
// PSRAM request/response bus: strobe + address out, busy/done/data back.
interface psram_line_fetch_if;
  import ogege_pkg::*;

  logic                o_stb;
  logic                o_we;
  logic [PSRAM_AW-1:0] o_addr;
  logic                i_busy;
  logic                i_done;
  logic [15:0]         i_dout;

  modport master (output o_stb, o_we, o_addr, input i_busy, i_done, i_dout);
  modport slave  (input o_stb, o_we, o_addr, output i_busy, i_done, i_dout);
endinterface

// File: rtl/psram_line_fetch_line_buffer.sv
// Ping-pong scanline store: simple dual-port RAM, one write port, one registered read port.
// Read data appears one cycle after rd_en; no backpressure, both ports usable every cycle.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 12
) (
  input  logic          clk_100mhz,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);
  logic [DW-1:0] ram [DEPTH];

  always_ff @(posedge clk_100mhz) begin
    if (wr_en) ram[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= ram[rd_addr];
  end
endmodule

// File: rtl/psram_line_fetch.sv
// Scanline prefetcher: fetches line n+1 from PSRAM while line n plays out of a ping-pong buffer.
// Pixel latency one pix_ce; PSRAM side waits on busy/done, a new line trigger aborts a late fetch.
module psram_line_fetch
  import ogege_pkg::*;
#(
  parameter int LINE_WORDS = 320,
  parameter int X_SHIFT    = 1,
  parameter int Y_SHIFT    = 1,
  parameter int STRIDE     = 640
) (
  input  logic                clk_100mhz,
  input  logic                rstn_i,
  input  logic                i_pix_ce,
  input  logic [9:0]          i_hcount,
  input  logic [8:0]          i_vcount,
  input  logic                i_de,
  input  logic [PSRAM_AW-1:0] i_frame_base,
  psram_line_fetch_if.master  psram,
  output logic [COLOR_W-1:0]  o_color,
  output logic                o_fetching,
  output logic                o_underrun
);
  localparam int BUF_AW = $clog2(2 * LINE_WORDS);
  localparam int K_W    = $clog2(LINE_WORDS);

  fetch_state_t        state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                drain_q, drain_d;
  logic                disp_bank, fill_bank;
  logic [PSRAM_AW-1:0] base_q, line_addr_q;
  logic                underrun_q, de_q, wr_en;
  logic                le, swap, frame_start, trig, rd_bank;
  logic [8:0]          tgt;
  logic [BUF_AW-1:0]   rd_idx, rd_addr, wr_addr;
  logic [COLOR_W-1:0]  rd_dat;
  logic                unused_dout_hi;

  assign le          = i_pix_ce && (i_hcount == 10'd0);
  assign swap        = le && (i_vcount < 9'(V_ACTIVE));
  assign frame_start = le && (i_vcount == 9'(V_ACTIVE));
  assign trig        = frame_start || (le && (i_vcount < 9'(V_ACTIVE - 1)));
  assign tgt         = frame_start ? 9'd0 : i_vcount + 9'd1;

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      disp_bank   <= 1'b0;
      fill_bank   <= 1'b1;
      base_q      <= '0;
      line_addr_q <= '0;
      underrun_q  <= 1'b0;
      de_q        <= 1'b0;
    end else begin
      underrun_q <= trig && (state_q != F_IDLE);
      if (swap) begin
        disp_bank <= fill_bank;
        fill_bank <= ~fill_bank;
      end
      if (frame_start) begin
        base_q      <= i_frame_base;
        line_addr_q <= i_frame_base;
      end else if (trig) begin
        line_addr_q <= base_q + PSRAM_AW'(tgt >> Y_SHIFT) * PSRAM_AW'(STRIDE);
      end
      if (i_pix_ce) de_q <= i_de;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= F_IDLE;
      k_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // An aborted request may already be accepted by the controller; drain_q swallows
  // its done and holds off the new strobe so that done is never taken as word 0.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q && !psram.i_done;
    wr_en   = 1'b0;
    if (trig) begin
      state_d = F_REQ;
      k_d     = '0;
      drain_d = (state_q != F_IDLE) && !psram.i_done;
    end else begin
      case (state_q)
        F_REQ: begin
          if (!drain_q && psram.i_busy) state_d = F_WAIT;
        end
        F_WAIT: begin
          if (psram.i_done) begin
            wr_en = 1'b1;
            if (k_q == K_W'(LINE_WORDS - 1)) begin
              state_d = F_IDLE;
            end else begin
              k_d     = k_q + K_W'(1);
              state_d = F_REQ;
            end
          end
        end
        default: state_d = F_IDLE;
      endcase
    end
  end

  assign psram.o_stb  = (state_q == F_REQ) && !drain_q;
  assign psram.o_we   = 1'b0;
  assign psram.o_addr = line_addr_q + (PSRAM_AW'(k_q) << 1);
  assign o_fetching   = (state_q != F_IDLE);
  assign o_underrun   = underrun_q;

  // At the line event the bank about to be displayed is read, so hcount 0 shows the new line.
  assign rd_bank = swap ? fill_bank : disp_bank;
  assign rd_idx  = BUF_AW'(i_hcount >> X_SHIFT);
  assign rd_addr = rd_bank ? rd_idx + BUF_AW'(LINE_WORDS) : rd_idx;
  assign wr_addr = fill_bank ? BUF_AW'(k_q) + BUF_AW'(LINE_WORDS) : BUF_AW'(k_q);
  assign unused_dout_hi = ^psram.i_dout[15:12];

  line_buffer #(
    .DEPTH(2 * LINE_WORDS),
    .AW   (BUF_AW),
    .DW   (COLOR_W)
  ) u_buf (
    .clk_100mhz(clk_100mhz),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_dat    (psram.i_dout[COLOR_W-1:0]),
    .rd_en     (i_pix_ce),
    .rd_addr   (rd_addr),
    .rd_dat    (rd_dat)
  );

  assign o_color = de_q ? rd_dat : '0;
endmodule

// File: tb/tb_psram_line_fetch.sv
// Directed bench for psram_line_fetch with a behavioural PSRAM returning addr[12:1] as data.
module tb_psram_line_fetch;
  import ogege_pkg::*;

  logic        clk_100mhz   = 1'b0;
  logic        rstn_i       = 1'b0;
  logic        i_pix_ce     = 1'b0;
  logic        i_de         = 1'b0;
  logic [9:0]  i_hcount     = '0;
  logic [8:0]  i_vcount     = '0;
  logic [23:0] i_frame_base = '0;
  logic [11:0] o_color;
  logic        o_fetching;
  logic        o_underrun;

  psram_line_fetch_if bus ();

  psram_line_fetch dut (
    .clk_100mhz  (clk_100mhz),
    .rstn_i      (rstn_i),
    .i_pix_ce    (i_pix_ce),
    .i_hcount    (i_hcount),
    .i_vcount    (i_vcount),
    .i_de        (i_de),
    .i_frame_base(i_frame_base),
    .psram       (bus),
    .o_color     (o_color),
    .o_fetching  (o_fetching),
    .o_underrun  (o_underrun)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Behavioural PSRAM controller: accepts a strobe when idle, answers m_delay+1 cycles later.
  int unsigned m_delay = 2;
  int unsigned m_cnt;
  logic        m_busy;
  logic [23:0] m_addr;
  logic [23:0] acc_addr[$];
  int          n_done = 0;

  always @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      m_addr     <= '0;
      bus.i_done <= 1'b0;
      bus.i_dout <= '0;
    end else begin
      bus.i_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy     <= 1'b0;
          bus.i_done <= 1'b1;
          bus.i_dout <= {4'hA, m_addr[12:1]};
          n_done     <= n_done + 1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (bus.o_stb) begin
        m_busy <= 1'b1;
        m_addr <= bus.o_addr;
        m_cnt  <= m_delay;
        acc_addr.push_back(bus.o_addr);
      end
    end
  end
  assign bus.i_busy = m_busy;

  int n_run  = 0;
  int n_fail = 0;
  int snap   = 0;
  int d_snap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask

  task automatic line_event(input logic [8:0] v);
    i_vcount = v;
    i_hcount = 10'd0;
    i_de     = (v < 9'd480);
    i_pix_ce = 1'b1;
    tick(1);
    i_pix_ce = 1'b0;
    i_hcount = 10'd1;
    snap     = acc_addr.size();
    d_snap   = n_done;
  endtask

  task automatic pixel(input logic [9:0] h, input logic de);
    tick(3);
    i_hcount = h;
    i_de     = de;
    i_pix_ce = 1'b1;
    tick(1);
    i_pix_ce = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (o_fetching && c < budget) begin
      tick(1);
      c++;
    end
    chk(tag, 32'(o_fetching), 32'd0);
  endtask

  function automatic logic [31:0] first_acc();
    return (acc_addr.size() > snap) ? 32'(acc_addr[snap]) : 32'hDEADBEEF;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int stb_seen;

    tick(3);
    chk("rst_stb", 32'(bus.o_stb), 0);
    chk("rst_we", 32'(bus.o_we), 0);
    chk("rst_addr", 32'(bus.o_addr), 0);
    chk("rst_color", 32'(o_color), 0);
    chk("rst_fetching", 32'(o_fetching), 0);
    chk("rst_underrun", 32'(o_underrun), 0);
    rstn_i = 1'b1;
    tick(2);

    line_event(9'd480);
    chk("f0_start", 32'(o_fetching), 1);
    chk("f0_no_uf", 32'(o_underrun), 0);
    chk("f0_we", 32'(bus.o_we), 0);
    wait_idle("f0_done", 4000);
    chk("f0_count", 32'(acc_addr.size() - snap), 320);
    chk("f0_dones", 32'(n_done - d_snap), 320);
    errs = 0;
    for (int k = 0; k < 320 && snap + k < acc_addr.size(); k++)
      if (acc_addr[snap + k] !== 24'(2 * k)) errs++;
    chk("f0_addr_seq", 32'(errs), 0);

    line_event(9'd0);
    chk("pix_h0", 32'(o_color), 12'h000);
    pixel(10'd1, 1'b1);
    chk("pix_h1", 32'(o_color), 12'h000);
    pixel(10'd2, 1'b1);
    chk("pix_h2", 32'(o_color), 12'h001);
    pixel(10'd3, 1'b1);
    chk("pix_h3", 32'(o_color), 12'h001);
    wait_idle("t1_done", 4000);
    chk("t1_addr", first_acc(), 0);

    line_event(9'd1);
    wait_idle("t2_done", 4000);
    chk("t2_addr", first_acc(), 640);
    pixel(10'd10, 1'b0);
    chk("blank", 32'(o_color), 12'h000);
    pixel(10'd10, 1'b1);
    chk("pix_h10", 32'(o_color), 12'h005);

    m_delay = 20;
    line_event(9'd2);
    chk("t3_no_uf", 32'(o_underrun), 0);
    tick(200);
    line_event(9'd3);
    chk("uf_pulse", 32'(o_underrun), 1);
    tick(1);
    chk("uf_one_cycle", 32'(o_underrun), 0);
    wait_idle("t4_done", 10000);
    chk("t4_addr", first_acc(), 1280);
    chk("t4_count", 32'(acc_addr.size() - snap), 320);
    m_delay = 2;

    i_frame_base = 24'h100100;
    line_event(9'd4);
    chk("uf_word0", 32'(o_color), 12'h280);
    pixel(10'd2, 1'b1);
    chk("uf_word1", 32'(o_color), 12'h281);
    wait_idle("t5_done", 4000);
    chk("t5_old_base", first_acc(), 1280);

    line_event(9'd479);
    tick(5);
    chk("v479_idle", 32'(o_fetching), 0);
    chk("v479_no_req", 32'(acc_addr.size() - snap), 0);

    line_event(9'd480);
    chk("f1_no_uf", 32'(o_underrun), 0);
    wait_idle("f1_done", 4000);
    chk("f1_new_base", first_acc(), 24'h100100);

    line_event(9'd0);
    chk("pix_new_base", 32'(o_color), 12'h080);
    chk("req_stb", 32'(bus.o_stb), 1);
    chk("req_addr", 32'(bus.o_addr), 24'h100100);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst_stb", 32'(bus.o_stb), 0);
    chk("arst_fetching", 32'(o_fetching), 0);
    chk("arst_addr", 32'(bus.o_addr), 0);
    tick(2);
    rstn_i = 1'b1;
    stb_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.o_stb) stb_seen++;
    end
    chk("post_rst_no_req", 32'(stb_seen), 0);
    chk("post_rst_disp", 32'(dut.disp_bank), 0);
    line_event(9'd1);
    chk("post_rst_stb", 32'(bus.o_stb), 1);
    chk("post_rst_addr", 32'(bus.o_addr), 640);
    wait_idle("post_rst_done", 4000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
